// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// One shift-add (multiply) or restoring-divide step per cycle; WIDTH steps
// in CALC, then a single FIX cycle applies signs and writes HI/LO.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, op, a, b        request: op 1000 MUL, 1001 MULU, 1010 DIV, 1011 DIVU
//   cancel                 flush; aborts an operation in flight, blocks start
//   hi_we/hi_wdata,
//   lo_we/lo_wdata         mthi/mtlo writes, honoured only while not busy
//   busy                   registered; high while an operation is in flight
//   done                   registered one-cycle pulse after HI/LO update
//   hi, lo                 architectural HI/LO registers
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // remainder follows dividend sign
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               op_valid;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Next-state, datapath step and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_orig_d  = a_orig_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    op_valid  = (op[3:2] == 2'b10);
    op_signed = ~op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditionally add multiplicand to upper half, shift right.
    mul_sum = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    // Divide step: shifted remainder needs WIDTH+1 bits before the compare.
    div_top = acc_q[ACC_W-1:WIDTH-1];
    div_ge  = (div_top >= {1'b0, opnd_q});
    div_rem = WIDTH'(div_top - {1'b0, opnd_q});

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];

    // mthi/mtlo only while idle; an accepted start may still take the write.
    if (!busy_q && hi_we) hi_d = hi_wdata;
    if (!busy_q && lo_we) lo_d = lo_wdata;

    unique case (state_q)
      IDLE: begin
        if (start && op_valid && !cancel) begin
          is_div_d  = op[1];
          a_orig_d  = a;
          dz_d      = (b == '0);
          neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op_signed && a[WIDTH-1];
          opnd_d    = op[1] ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                           : {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[ACC_W-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = a_orig_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_orig_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_orig_q  <= a_orig_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, randomized
// back-to-back operations against a 64-bit arithmetic reference model,
// HI/LO writes, busy-start rejection, cancel and asynchronous reset.
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         cancel;
  logic         hi_we, lo_we;
  logic [W-1:0] hi_wdata, lo_wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  task automatic model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ehi = '0; elo = '0;
    case (mop)
      4'b1000: begin sp = sa * sb; ehi = sp[63:32]; elo = sp[31:0]; end
      4'b1001: begin up = 64'(ma) * 64'(mb); ehi = up[63:32]; elo = up[31:0]; end
      4'b1010: begin
        if (mb == 0) begin ehi = ma; elo = '1; end
        else begin sq = sa / sb; sr = sa % sb; ehi = sr[31:0]; elo = sq[31:0]; end
      end
      default: begin
        if (mb == 0) begin ehi = ma; elo = '1; end
        else begin ehi = ma % mb; elo = ma / mb; end
      end
    endcase
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue an op at posedge+1 and follow it to done (bounded). Returns at done cycle.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                       output int busy_n, output int done_at);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = 0; done_at = 0; rhi = 'x; rlo = 'x;
    for (int k = 1; k <= 60; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = k; rhi = hi; rlo = lo;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; op = 0; a = 0; b = 0; cancel = 0;
    hi_we = 0; lo_we = 0; hi_wdata = 0; lo_wdata = 0;
    #12;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) $display("FAIL reset_outputs busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    else n_pass++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) $display("FAIL post_reset_idle busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [3:0]   ops [6] = '{4'b1000, 4'b1001, 4'b1011, 4'b1010, 4'b1010, 4'b1010};
    logic [W-1:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [W-1:0] bs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] ehs [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5};
    logic [W-1:0] els [6] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] rh, rl;
    int bn, da;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], rh, rl, bn, da);
      n_checks++;
      if (rh !== ehs[i] || rl !== els[i]) $display("FAIL directed_%0d hi=%h lo=%h required hi=%h lo=%h", i, rh, rl, ehs[i], els[i]);
      else n_pass++;
      n_checks++;
      if (bn !== 33 || da !== 34) $display("FAIL directed_timing_%0d busy_cycles=%0d done_at=%0d required 33/34", i, bn, da);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL directed_busy_in_done_%0d busy=%b required 0", i, busy);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) $display("FAIL directed_done_pulse_%0d done=%b required 0", i, done);
      else n_pass++;
    end
  endtask

  task automatic test_invalid_op();
    logic [3:0] bad [3] = '{4'b0111, 4'b1100, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      start = 1; op = bad[i]; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL invalid_op_%0d busy=%b required 0", i, busy);
      else n_pass++;
    end
  endtask

  // Consecutive random ops, each started in the previous op's done cycle.
  task automatic test_back_to_back();
    logic [W-1:0] rh, rl, eh, el, x, y;
    logic [3:0] o;
    int bn, da;
    for (int i = 0; i < 40; i++) begin
      o = 4'b1000 | 4'($urandom_range(0, 3));
      x = pick_operand(); y = pick_operand();
      model(o, x, y, eh, el);
      do_op(o, x, y, rh, rl, bn, da);
      n_checks++;
      if (rh !== eh || rl !== el || da !== 34)
        $display("FAIL random_%0d op=%b a=%h b=%h hi=%h lo=%h done_at=%0d required hi=%h lo=%h done_at=34", i, o, x, y, rh, rl, da, eh, el);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hilo_write();
    logic [W-1:0] rh, rl;
    int bn, da;
    lo_we = 1; lo_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    lo_we = 0;
    n_checks++;
    if (lo !== 32'h1234_5678) $display("FAIL mtlo_idle lo=%h required 12345678", lo);
    else n_pass++;
    // hi write accepted together with start, then overwritten by the result.
    hi_we = 1; hi_wdata = 32'hCAFE_0001; start = 1; op = 4'b1001; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    hi_we = 0; start = 0;
    n_checks++;
    if (hi !== 32'hCAFE_0001 || busy !== 1'b1) $display("FAIL mthi_with_start hi=%h busy=%b required cafe0001/1", hi, busy);
    else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    lo_we = 1; lo_wdata = 32'hDEAD_BEEF; hi_we = 1; hi_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    lo_we = 0; hi_we = 0;
    n_checks++;
    if (lo !== 32'h1234_5678 || hi !== 32'hCAFE_0001) $display("FAIL mt_while_busy hi=%h lo=%h required cafe0001/12345678", hi, lo);
    else n_pass++;
    // start while busy must be ignored.
    start = 1; op = 4'b1011; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    bn = 0; da = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin da = k; break; end
      @(posedge clk); #1;
    end
    rh = hi; rl = lo;
    n_checks++;
    if (da == 0 || rh !== 32'd0 || rl !== 32'd42) $display("FAIL start_while_busy hi=%h lo=%h done_seen=%0d required 0/2a and done", rh, rl, da);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL no_queued_op busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_cancel();
    int seen;
    lo_we = 1; lo_wdata = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    lo_we = 0;
    start = 1; op = 4'b1011; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    n_checks++;
    if (busy !== 1'b0 || lo !== 32'hAAAA_AAAA || done !== 1'b0)
      $display("FAIL cancel_calc busy=%b lo=%h done=%b required 0/aaaaaaaa/0", busy, lo, done);
    else n_pass++;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0 || lo !== 32'hAAAA_AAAA) $display("FAIL cancel_no_done done_count=%0d lo=%h required 0/aaaaaaaa", seen, lo);
    else n_pass++;
    // cancel in IDLE blocks a same-cycle start.
    start = 1; cancel = 1; op = 4'b1001; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 0; cancel = 0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cancel_blocks_start busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] rh, rl;
    int bn, da;
    start = 1; op = 4'b1001; a = 32'hFFFF_0000; b = 32'h0001_2345;
    @(posedge clk); #1;
    start = 0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(4'b1001, 32'd3, 32'd4, rh, rl, bn, da);
    n_checks++;
    if (rl !== 32'd12 || rh !== 32'd0 || da !== 34) $display("FAIL mulu_after_reset hi=%h lo=%h done_at=%0d required 0/c/34", rh, rl, da);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid_op();
    test_back_to_back();
    test_hilo_write();
    test_cancel();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
